// File: rtl/pu_msp430_trace_pkg.sv
// Shared types and constants for the MSP430 instruction trace recorder.
package pu_msp430_trace_pkg;

    localparam int TRACE_DEPTH_LOG2 = 4;
    localparam int TRACE_CYC_W      = 8;

    // Capture state: filling freely, counting down after a trigger, or holding history
    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        POST   = 2'd1,
        FROZEN = 2'd2
    } trace_state_e;

    // One trace record; field order matches the packed RAM word {irq, pc, op, cyc}
    typedef struct packed {
        logic                   irq;
        logic [15:0]            pc;
        logic [15:0]            op;
        logic [TRACE_CYC_W-1:0] cyc;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    // Packed record width for an arbitrary cycle-count width
    function automatic int rec_width(input int cyc_w);
        return 33 + cyc_w;
    endfunction

endpackage

// File: rtl/pu_msp430_trace_ram.sv
// Record storage: one synchronous write port, one registered read port.
module pu_msp430_trace_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 41
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_r;

    // Storage array write; contents are don't-care until written
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: updates only on a pop so the last popped record is held
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pu_msp430_trace_buffer.sv
// Circular instruction trace buffer with PC-match trigger, post-trigger
// capture count and an oldest-first drain port for frozen history.
module pu_msp430_trace_buffer
    import pu_msp430_trace_pkg::*;
#(
    parameter int DEPTH_LOG2 = TRACE_DEPTH_LOG2,
    parameter int CYC_W      = TRACE_CYC_W
) (
    input  logic                  mclk,
    input  logic                  puc_rst,
    input  logic                  decode,
    input  logic [15:0]           ir,
    input  logic [15:0]           pc,
    input  logic                  irq_detect,
    input  logic                  trig_en,
    input  logic [15:0]           trig_pc,
    input  logic [DEPTH_LOG2-1:0] post_cnt,
    input  logic                  rearm,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic                  rd_irq,
    output logic [15:0]           rd_pc,
    output logic [15:0]           rd_op,
    output logic [CYC_W-1:0]      rd_cyc,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  frozen,
    output logic                  overflow
);

    localparam int                  REC_W    = rec_width(CYC_W);
    localparam int                  DEPTH    = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [CYC_W-1:0]    CYC_MAX  = '1;
    localparam logic [CYC_W-1:0]    CYC_ONE  = CYC_W'(1);

    trace_state_e           state_r;
    logic [DEPTH_LOG2-1:0]  wr_ptr_r;
    logic [DEPTH_LOG2-1:0]  rd_ptr_r;
    logic [DEPTH_LOG2-1:0]  remaining_r;
    logic [DEPTH_LOG2:0]    count_r;
    logic [CYC_W-1:0]       cyc_r;
    logic                   overflow_r;
    logic                   frozen_r;
    logic                   rd_valid_r;

    logic                   wr_en_s;
    logic                   rd_en_s;
    logic                   trig_hit_s;
    logic                   full_s;
    logic [REC_W-1:0]       wr_data_s;
    logic [REC_W-1:0]       rd_data_s;

    // Qualify write/pop requests; rearm swallows everything in its cycle
    always_comb begin
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        trig_hit_s = trig_en && (pc == trig_pc);
        full_s     = (count_r == CNT_FULL);
        wr_data_s  = {irq_detect, pc, ir, cyc_r};
        if (rearm) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            wr_en_s = decode && (state_r != FROZEN);
            rd_en_s = rd_req && (state_r == FROZEN) && (count_r != '0);
        end
    end

    // Length of the instruction in flight: restarts at 1 on decode, saturates
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cyc_r <= '0;
        end else if (decode) begin
            cyc_r <= CYC_ONE;
        end else if (cyc_r != CYC_MAX) begin
            cyc_r <= cyc_r + CYC_ONE;
        end
    end

    // Capture FSM, pointers, occupancy, overflow flag and read strobe
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_r     <= ARMED;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            remaining_r <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            frozen_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else if (rearm) begin
            state_r     <= ARMED;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            remaining_r <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            frozen_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (full_s) begin
                    // Oldest record is overwritten: read side follows the write side
                    rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                    overflow_r <= 1'b1;
                end else begin
                    count_r <= count_r + CNT_ONE;
                end
            end else if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                count_r  <= count_r - CNT_ONE;
            end
            case (state_r)
                ARMED: begin
                    if (wr_en_s && trig_hit_s) begin
                        if (post_cnt == '0) begin
                            state_r  <= FROZEN;
                            frozen_r <= 1'b1;
                        end else begin
                            remaining_r <= post_cnt;
                            state_r     <= POST;
                        end
                    end
                end
                POST: begin
                    if (wr_en_s) begin
                        remaining_r <= remaining_r - PTR_ONE;
                        if (remaining_r == PTR_ONE) begin
                            state_r  <= FROZEN;
                            frozen_r <= 1'b1;
                        end
                    end
                end
                FROZEN: begin
                    frozen_r <= 1'b1;
                end
                default: begin
                    state_r  <= ARMED;
                    frozen_r <= 1'b0;
                end
            endcase
        end
    end

    pu_msp430_trace_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (REC_W)
    ) u_ram (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    assign {rd_irq, rd_pc, rd_op, rd_cyc} = rd_data_s;
    assign rd_valid = rd_valid_r;
    assign count    = count_r;
    assign frozen   = frozen_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_pu_msp430_trace_buffer.sv
// Directed bench for the trace buffer with a behavioural capture model
// and a scoreboard of records expected on the read port.
module tb_pu_msp430_trace_buffer;
    import pu_msp430_trace_pkg::*;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        decode = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic [15:0] pc = 16'h0000;
    logic        irq_detect = 1'b0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_pc = 16'h0000;
    logic [3:0]  post_cnt = 4'd0;
    logic        rearm = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_valid;
    logic        rd_irq;
    logic [15:0] rd_pc;
    logic [15:0] rd_op;
    logic [7:0]  rd_cyc;
    logic [4:0]  count;
    logic        frozen;
    logic        overflow;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int         m_cyc   = 0;
    int         m_state = 0;   // 0 armed, 1 post, 2 frozen
    int         m_rem   = 0;
    bit         m_ovf   = 1'b0;
    trace_rec_t m_q[$];
    trace_rec_t exp_q[$];

    pu_msp430_trace_buffer dut (
        .mclk       (mclk),
        .puc_rst    (puc_rst),
        .decode     (decode),
        .ir         (ir),
        .pc         (pc),
        .irq_detect (irq_detect),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_cnt   (post_cnt),
        .rearm      (rearm),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_irq     (rd_irq),
        .rd_pc      (rd_pc),
        .rd_op      (rd_op),
        .rd_cyc     (rd_cyc),
        .count      (count),
        .frozen     (frozen),
        .overflow   (overflow)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from current inputs, then compare after the edge
    task automatic cycle();
        bit         acc_rd;
        trace_rec_t r;
        trace_rec_t e;
        acc_rd = 1'b0;
        if (rearm) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_rem   = 0;
            m_state = 0;
        end else begin
            acc_rd = (m_state == 2) && rd_req && (m_q.size() > 0);
            if (acc_rd) exp_q.push_back(m_q.pop_front());
            if (decode && m_state != 2) begin
                r.irq = irq_detect;
                r.pc  = pc;
                r.op  = ir;
                r.cyc = 8'(m_cyc);
                if (m_q.size() == 16) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
                m_q.push_back(r);
                if (m_state == 0) begin
                    if (trig_en && pc == trig_pc) begin
                        if (post_cnt == 4'd0) m_state = 2;
                        else begin
                            m_rem   = int'(post_cnt);
                            m_state = 1;
                        end
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_state = 2;
                end
            end
        end
        m_cyc = decode ? 1 : ((m_cyc == 255) ? 255 : m_cyc + 1);
        @(posedge mclk);
        #1;
        chk("rd_valid", 64'(rd_valid), 64'(acc_rd));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("frozen", 64'(frozen), 64'(m_state == 2));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (acc_rd) begin
            e = exp_q.pop_front();
            chk("rd_irq", 64'(rd_irq), 64'(e.irq));
            chk("rd_pc", 64'(rd_pc), 64'(e.pc));
            chk("rd_op", 64'(rd_op), 64'(e.op));
            chk("rd_cyc", 64'(rd_cyc), 64'(e.cyc));
        end
    endtask

    task automatic dec(input logic [15:0] p, input logic irq);
        decode     = 1'b1;
        pc         = p;
        ir         = p ^ 16'h5A5A;
        irq_detect = irq;
        cycle();
        decode     = 1'b0;
        irq_detect = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic rd();
        rd_req = 1'b1;
        cycle();
        rd_req = 1'b0;
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        cycle();
        rearm = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_frozen", 64'(frozen), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", {23'd0, rd_irq, rd_pc, rd_op, rd_cyc}, 64'd0);
        #5 puc_rst = 1'b0;

        // 1: trigger on third decode with two post-trigger records
        trig_en  = 1'b1;
        trig_pc  = 16'hF004;
        post_cnt = 4'd2;
        for (int i = 0; i < 5; i++) dec(16'hF000 + 16'(2 * i), 1'b0);
        chk("t1_frozen", 64'(frozen), 64'd1);
        chk("t1_count", 64'(count), 64'd5);
        for (int i = 0; i < 5; i++) begin
            rd();
            chk("t1_pc", 64'(rd_pc), 64'(16'hF000 + 16'(2 * i)));
        end
        rd();
        chk("t1_empty_rd", 64'(rd_valid), 64'd0);

        // 2: wrap with overwrite, trigger on 20th decode
        do_rearm();
        trig_en = 1'b0;
        for (int i = 0; i < 19; i++) dec(16'h1000 + 16'(2 * i), 1'b0);
        trig_en  = 1'b1;
        trig_pc  = 16'h1026;
        post_cnt = 4'd0;
        dec(16'h1026, 1'b0);
        chk("t2_count", 64'(count), 64'd16);
        chk("t2_overflow", 64'(overflow), 64'd1);
        rd();
        chk("t2_first_pc", 64'(rd_pc), 64'h1008);

        // 3: cycle counts 1, 3 and a saturated 300
        do_rearm();
        trig_pc = 16'h2006;
        dec(16'h2000, 1'b0);
        dec(16'h2002, 1'b0);
        idle(2);
        dec(16'h2004, 1'b0);
        idle(299);
        dec(16'h2006, 1'b0);
        rd();
        rd();
        chk("t3_cyc1", 64'(rd_cyc), 64'd1);
        rd();
        chk("t3_cyc3", 64'(rd_cyc), 64'd3);
        rd();
        chk("t3_cyc_sat", 64'(rd_cyc), 64'd255);

        // 4: read while armed, then rearm colliding with a trigger decode
        do_rearm();
        trig_pc = 16'h3100;
        for (int i = 0; i < 17; i++) dec(16'h3000 + 16'(2 * i), 1'b0);
        rd();
        chk("t4_armed_rd", 64'(rd_valid), 64'd0);
        chk("t4_count", 64'(count), 64'd16);
        rearm  = 1'b1;
        decode = 1'b1;
        pc     = 16'h3100;
        cycle();
        rearm  = 1'b0;
        decode = 1'b0;
        chk("t4_frozen", 64'(frozen), 64'd0);
        chk("t4_count0", 64'(count), 64'd0);
        chk("t4_ovf0", 64'(overflow), 64'd0);
        idle(1);

        // 5: interrupt flag on a single record
        trig_pc  = 16'h4004;
        post_cnt = 4'd1;
        dec(16'h4000, 1'b0);
        dec(16'hFFFE, 1'b1);
        dec(16'h4004, 1'b0);
        dec(16'h4006, 1'b0);
        chk("t5_frozen", 64'(frozen), 64'd1);
        rd();
        chk("t5_irq0", 64'(rd_irq), 64'd0);
        rd();
        chk("t5_irq1", 64'(rd_irq), 64'd1);
        rd();
        chk("t5_irq2", 64'(rd_irq), 64'd0);
        rd();
        chk("t5_irq3", 64'(rd_irq), 64'd0);

        // 6: asynchronous reset in the middle of a readout
        do_rearm();
        trig_pc  = 16'h5006;
        post_cnt = 4'd0;
        for (int i = 0; i < 4; i++) dec(16'h5000 + 16'(2 * i), 1'b0);
        rd();
        chk("t6_count3", 64'(count), 64'd3);
        chk("t6_valid", 64'(rd_valid), 64'd1);
        #2 puc_rst = 1'b1;
        #1;
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_frozen", 64'(frozen), 64'd0);
        chk("t6_rst_valid", 64'(rd_valid), 64'd0);
        chk("t6_rst_pc", 64'(rd_pc), 64'd0);
        m_q.delete();
        exp_q.delete();
        m_cyc   = 0;
        m_state = 0;
        m_rem   = 0;
        m_ovf   = 1'b0;
        #3 puc_rst = 1'b0;
        idle(3);
        dec(16'h6000, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
